mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port ws_allowin, input, 1: WB stage can accept an instruction this cycle.
REQ-004 SHALL have port ms_allowin, output, 1: MEM can accept from EXE this cycle.
REQ-005 SHALL have port es_to_ms_valid, input, 1: EXE presents a valid instruction.
REQ-006 SHALL have port es_to_ms_bus, input, 76: {ld_op[4:0], res_from_mem, gr_we, dest[4:0], exe_result[31:0], pc[31:0]}, MSB first.
REQ-007 SHALL decode ld_op[4:0] as {ld_b, ld_h, ld_w, ld_bu, ld_hu}, one-hot or zero.
REQ-008 SHALL have port data_sram_rdata, input, 32: synchronous SRAM read data, valid the cycle after EXE issues the address.
REQ-009 SHALL have port ms_to_ws_valid, output, 1: MEM presents a valid instruction to WB.
REQ-010 SHALL have port ms_to_ws_bus, output, 70: {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
REQ-011 SHALL have port out_ms_valid, output, 1: ms_valid, for ID hazard detection.
REQ-012 SHALL have port ms_fwd_bus, output, 38: {ms_valid & gr_we, dest[4:0], final_result[31:0]}, for ID forwarding.

Function
REQ-013 SHALL hold ms_valid and a 76-bit bus register; on es_to_ms_valid & ms_allowin, SHALL load the bus register with es_to_ms_bus.
REQ-014 SHALL update ms_valid <= es_to_ms_valid whenever ms_allowin=1; otherwise ms_valid holds.
REQ-015 SHALL drive ms_ready_go=1 (single-cycle stage); ms_allowin = !ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go.
REQ-016 SHALL capture data_sram_rdata into a 32-bit hold register in the first cycle an instruction occupies MEM, and set a captured flag.
REQ-017 SHALL use live data_sram_rdata in the first cycle and the hold register in later stall cycles (ws_allowin=0).
REQ-018 SHALL clear the captured flag when a new instruction enters MEM, or when MEM empties.
REQ-019 SHALL form the effective rdata by byte-lane select on exe_result[1:0]: byte = rdata[8*a+7:8*a]; half = rdata[31:16] if a[1], else rdata[15:0].
REQ-020 SHALL extend ld_b and ld_h by sign, ld_bu and ld_hu by zero, and pass ld_w as the full 32-bit word.
REQ-021 SHALL set final_result = load value when res_from_mem=1, else exe_result.
REQ-022 SHALL drive the gr_we field of ms_fwd_bus low when ms_valid=0; ms_to_ws_bus fields are don't-care when ms_to_ws_valid=0.
REQ-023 SHALL treat misaligned ld_h/ld_w addresses without exception: ld_w ignores a[1:0]; ld_h uses a[1] only.
REQ-024 SHALL accept a new instruction in the same cycle the current one leaves (ws_allowin=1), with no bubble.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, clear ms_valid and the captured flag; the bus and hold registers need no reset.
REQ-026 SHALL, after reset: ms_allowin=1, ms_to_ws_valid=0, out_ms_valid=0, ms_fwd_bus[37]=0.
REQ-027 SHALL let reset take priority over a simultaneous es_to_ms_valid; the instruction is dropped.

Verification
REQ-028 SHALL cover: ld_b, a=2'b11, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80; the same with ld_bu -> 0x0000_0080.
REQ-029 SHALL cover: ld_h, a=2'b10, rdata=0x8001_7FFF -> 0xFFFF_8001; ld_hu, a=2'b00 -> 0x0000_7FFF.
REQ-030 SHALL cover: non-load, gr_we=1, dest=5, exe_result=0x1234_5678 -> ms_to_ws_bus={1,5,0x12345678,pc} and ms_fwd_bus={1,5,0x12345678} one cycle after entry.
REQ-031 SHALL cover: ld_w enters, rdata=0xDEAD_BEEF in the first cycle, ws_allowin=0 for 3 cycles while rdata changes to 0 -> final_result stays 0xDEADBEEF, ms_allowin=0 during the stall.
REQ-032 SHALL cover: back-to-back valid instructions with ws_allowin=1 -> one instruction per cycle on ms_to_ws_valid, no bubble.
REQ-033 SHALL cover: reset asserted while ms_valid=1 and stalled -> next cycle ms_valid=0, ms_allowin=1, ms_fwd_bus[37]=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between EXE and WB.
//   Registers the EXE instruction, selects and extends load data from the
//   synchronous data SRAM, and forwards the result to WB and to ID.
// Latency: one cycle per instruction; the result is combinational from the
//   stage register and the SRAM read data.
// Backpressure: holds its instruction while ws_allowin=0. The SRAM word is
//   captured on the first cycle so stalls do not depend on the SRAM output.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   ws_allowin          - WB can accept this cycle
//   ms_allowin          - MEM can accept from EXE this cycle
//   es_to_ms_valid/bus  - incoming instruction from EXE
//   data_sram_rdata     - SRAM read data, valid in the first MEM cycle
//   ms_to_ws_valid/bus  - outgoing instruction to WB
//   out_ms_valid        - stage occupancy, used for ID hazard detection
//   ms_fwd_bus          - {write-enable, dest, result}, used for ID forwarding
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [75:0] es_to_ms_bus,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic        out_ms_valid,
  output logic [37:0] ms_fwd_bus
);

  logic        ms_valid;
  logic        ms_ready_go;
  logic [75:0] ms_bus;
  logic [31:0] rdata_hold;
  logic        rdata_captured;

  // Fields of the stage register.
  logic [4:0]  ld_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic [31:0] pc;

  logic        ld_b, ld_h, ld_w, ld_bu, ld_hu;
  logic [1:0]  addr_lo;
  logic [31:0] rdata;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign {ld_op, res_from_mem, gr_we, dest, exe_result, pc} = ms_bus;
  assign {ld_b, ld_h, ld_w, ld_bu, ld_hu} = ld_op;
  assign addr_lo = exe_result[1:0];

  // Handshake.
  assign ms_ready_go    = 1'b1;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign out_ms_valid   = ms_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_bus <= es_to_ms_bus;
    end
  end

  // The SRAM only presents the word in the first MEM cycle. Whenever the
  // stage is about to change occupant (or empty) the flag drops; otherwise
  // the first stalled cycle grabs the live word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_captured <= 1'b0;
    end else if (ms_allowin) begin
      rdata_captured <= 1'b0;
    end else if (ms_valid && !rdata_captured) begin
      rdata_captured <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!ms_allowin && ms_valid && !rdata_captured) begin
      rdata_hold <= data_sram_rdata;
    end
  end

  assign rdata = rdata_captured ? rdata_hold : data_sram_rdata;

  // Lane selection; misaligned halfwords use addr bit 1 only and words
  // ignore the low address bits entirely.
  always_comb begin
    byte_val = 8'h00;
    case (addr_lo)
      2'b00:   byte_val = rdata[7:0];
      2'b01:   byte_val = rdata[15:8];
      2'b10:   byte_val = rdata[23:16];
      default: byte_val = rdata[31:24];
    endcase
  end

  assign half_val = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_val = rdata;
    if (ld_b)       load_val = {{24{byte_val[7]}}, byte_val};
    else if (ld_bu) load_val = {24'h000000, byte_val};
    else if (ld_h)  load_val = {{16{half_val[15]}}, half_val};
    else if (ld_hu) load_val = {16'h0000, half_val};
    else if (ld_w)  load_val = rdata;
  end

  assign final_result = res_from_mem ? load_val : exe_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid && gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        out_ms_valid;
  logic [37:0] ms_fwd_bus;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_H  = 5'b01000;
  localparam logic [4:0] OP_W  = 5'b00100;
  localparam logic [4:0] OP_BU = 5'b00010;
  localparam logic [4:0] OP_HU = 5'b00001;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .out_ms_valid    (out_ms_valid),
    .ms_fwd_bus      (ms_fwd_bus)
  );

  function automatic logic [75:0] mk(input logic [4:0] op, input logic rfm,
                                     input logic we, input logic [4:0] dst,
                                     input logic [31:0] res, input logic [31:0] pcv);
    return {op, rfm, we, dst, res, pcv};
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge (inputs change and outputs are
  // sampled half a cycle away from the rising edge).
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset           = 1'b1;
    ws_allowin      = 1'b1;
    es_to_ms_valid  = 1'b0;
    es_to_ms_bus    = '0;
    data_sram_rdata = '0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_allowin",  70'(ms_allowin), 70'd1);
    chk("rst_to_ws_v",  70'(ms_to_ws_valid), 70'd0);
    chk("rst_ms_valid", 70'(out_ms_valid), 70'd0);
    chk("rst_fwd_we",   70'(ms_fwd_bus[37]), 70'd0);

    // Back-to-back chain with WB always ready.
    cyc();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(OP_B, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h0000_0100);
    cyc();
    es_to_ms_bus    = mk(OP_BU, 1'b1, 1'b1, 5'd4, 32'h0000_1003, 32'h0000_0104);
    data_sram_rdata = 32'h80FF_1234;
    #1;
    chk("ldb_valid",  70'(ms_to_ws_valid), 70'd1);
    chk("ldb_result", 70'(ms_to_ws_bus[63:32]), 70'hFFFF_FF80);
    chk("ldb_pc",     70'(ms_to_ws_bus[31:0]), 70'h0000_0100);
    chk("ldb_allowin", 70'(ms_allowin), 70'd1);
    cyc();
    es_to_ms_bus = mk(OP_H, 1'b1, 1'b1, 5'd6, 32'h0000_1002, 32'h0000_0108);
    #1;
    chk("ldbu_valid",  70'(ms_to_ws_valid), 70'd1);
    chk("ldbu_result", 70'(ms_to_ws_bus[63:32]), 70'h0000_0080);
    chk("ldbu_pc",     70'(ms_to_ws_bus[31:0]), 70'h0000_0104);
    cyc();
    es_to_ms_bus    = mk(OP_HU, 1'b1, 1'b1, 5'd7, 32'h0000_1000, 32'h0000_010C);
    data_sram_rdata = 32'h8001_7FFF;
    #1;
    chk("ldh_valid",  70'(ms_to_ws_valid), 70'd1);
    chk("ldh_result", 70'(ms_to_ws_bus[63:32]), 70'hFFFF_8001);
    chk("ldh_pc",     70'(ms_to_ws_bus[31:0]), 70'h0000_0108);
    cyc();
    es_to_ms_bus = mk(5'b00000, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_0110);
    #1;
    chk("ldhu_valid",  70'(ms_to_ws_valid), 70'd1);
    chk("ldhu_result", 70'(ms_to_ws_bus[63:32]), 70'h0000_7FFF);
    cyc();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu_valid", 70'(ms_to_ws_valid), 70'd1);
    chk("alu_ws_bus", ms_to_ws_bus, {1'b1, 5'd5, 32'h1234_5678, 32'h0000_0110});
    chk("alu_fwd_bus", 70'(ms_fwd_bus), 70'({1'b1, 5'd5, 32'h1234_5678}));
    cyc();
    #1;
    chk("empty_valid",  70'(ms_to_ws_valid), 70'd0);
    chk("empty_fwd_we", 70'(ms_fwd_bus[37]), 70'd0);
    chk("empty_allowin", 70'(ms_allowin), 70'd1);

    // Misaligned ld_w held across a three-cycle WB stall.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(OP_W, 1'b1, 1'b1, 5'd9, 32'h0000_2003, 32'h0000_0200);
    cyc();
    es_to_ms_bus    = mk(OP_W, 1'b1, 1'b1, 5'd10, 32'h0000_3000, 32'h0000_0300);
    data_sram_rdata = 32'hDEAD_BEEF;
    ws_allowin      = 1'b0;
    #1;
    chk("ldw_first_result", 70'(ms_to_ws_bus[63:32]), 70'hDEAD_BEEF);
    chk("ldw_first_allowin", 70'(ms_allowin), 70'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      data_sram_rdata = 32'h0000_0000;
      #1;
      chk("stall_result",  70'(ms_to_ws_bus[63:32]), 70'hDEAD_BEEF);
      chk("stall_allowin", 70'(ms_allowin), 70'd0);
      chk("stall_pc",      70'(ms_to_ws_bus[31:0]), 70'h0000_0200);
      chk("stall_valid",   70'(ms_to_ws_valid), 70'd1);
    end
    cyc();
    ws_allowin = 1'b1;
    #1;
    chk("release_allowin", 70'(ms_allowin), 70'd1);
    chk("release_result",  70'(ms_to_ws_bus[63:32]), 70'hDEAD_BEEF);
    cyc();
    // New instruction must see live SRAM data, not the old held word.
    es_to_ms_bus    = mk(OP_B, 1'b1, 1'b1, 5'd11, 32'h0000_4000, 32'h0000_0400);
    data_sram_rdata = 32'h1122_3344;
    ws_allowin      = 1'b0;
    #1;
    chk("next_pc",     70'(ms_to_ws_bus[31:0]), 70'h0000_0300);
    chk("next_result", 70'(ms_to_ws_bus[63:32]), 70'h1122_3344);
    cyc();
    data_sram_rdata = 32'h5555_5555;
    #1;
    chk("next_hold_result", 70'(ms_to_ws_bus[63:32]), 70'h1122_3344);
    chk("next_stall_allowin", 70'(ms_allowin), 70'd0);

    // Reset while stalled, with EXE offering an instruction at the same edge.
    reset = 1'b1;
    cyc();
    reset          = 1'b0;
    es_to_ms_valid = 1'b0;
    #1;
    chk("rst2_ms_valid", 70'(out_ms_valid), 70'd0);
    chk("rst2_allowin",  70'(ms_allowin), 70'd1);
    chk("rst2_fwd_we",   70'(ms_fwd_bus[37]), 70'd0);
    chk("rst2_to_ws_v",  70'(ms_to_ws_valid), 70'd0);
    cyc();
    #1;
    chk("rst2_dropped", 70'(out_ms_valid), 70'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
